hub75_fb_row_loader: RTL and testbench
======================================

// Module: hub75_fb_row_loader
// PURPOSE
//  Upstream feeder of the frame-buffer write-in stage. Accepts a raster-ordered pixel stream
//  (valid/ready), writes each row into the write-in double line buffer, then hands the row
//  over with a swap + store pulse once write-in is ready. Maps display line y to bank/row.
// PARAMETERS
//  N_BANKS   2   panel banks; display lines = N_BANKS*N_ROWS (power of 2)
//  N_ROWS    32  rows per bank (power of 2)
//  N_COLS    64  pixels per row (power of 2)
//  BITDEPTH  24  pixel width
//  LOG_N_BANKS/LOG_N_ROWS/LOG_N_COLS  auto, $clog2 of the above
// PORTS
//  clk           in   1            system clock
//  rst           in   1            asynchronous, active-high reset
//  in_data       in   BITDEPTH     pixel
//  in_sof        in   1            qualifies in_data as first pixel of a frame
//  in_valid      in   1            pixel present
//  in_ready      out  1            pixel accepted when in_valid & in_ready
//  wr_bank_addr  out  LOG_N_BANKS  bank of row being committed
//  wr_row_addr   out  LOG_N_ROWS   row within bank being committed
//  wr_row_store  out  1            1-cycle commit request to write-in
//  wr_row_rdy    in   1            write-in idle, may accept a new store
//  wr_row_swap   out  1            1-cycle line-buffer half swap
//  wr_data       out  BITDEPTH     = in_data
//  wr_col_addr   out  LOG_N_COLS   column counter
//  wr_en         out  1            = in_valid & in_ready
//  frame_done    out  1            1-cycle pulse when last line of frame committed
//  sync_err      out  1            1-cycle pulse on SOF resync (0 without macro)
// BEHAVIOUR
//  - Reset: state FILL, col=0, line=0; wr_row_store/swap/frame_done/sync_err=0; in_ready=1.
//  - Line counter y (LOG_N_BANKS+LOG_N_ROWS bits): bank = y[MSBs], row = y[LSBs].
//  - FILL: in_ready=1; each accepted pixel written at col, col++ (wraps mod N_COLS).
//    Accept at col=N_COLS-1 -> WAIT next cycle. Zero latency: wr_en same cycle as accept.
//  - WAIT: in_ready=0. If wr_row_rdy=1: assert wr_row_swap and wr_row_store together for
//    exactly this cycle with wr_bank_addr/wr_row_addr = current y; y++ (wraps to 0);
//    -> FILL. frame_done pulses same cycle if y was N_BANKS*N_ROWS-1. Else stay in WAIT.
//  - Swap is never issued while write-in busy (wr_row_rdy=0): the half being refilled is
//    the one write-in just finished reading. Commit-to-next-accept: 1 cycle.
//  - wr_row_rdy sampled only in WAIT; its deassertion the cycle after store is expected.
//  - wr_bank_addr/wr_row_addr driven from y continuously; valid on store cycle.
//  - Reset mid-row/mid-WAIT: partial row discarded, no store/swap issued, counters to 0.
// CONFIGURATION
//  HUB75_ROW_LOADER_SOF_RESYNC_EN
//   defined: accepted pixel with in_sof=1 while (col,y)!=(0,0) -> partial row dropped
//    (no commit), pixel written at col 0, col=1, y=0; sync_err pulses that cycle.
//    in_sof at (0,0) is normal, no pulse. in_sof in WAIT is not seen (in_ready=0); the
//    pending row commits first, then resync applies on acceptance.
//   undefined: in_sof ignored, sync_err tied 0, pure free-running raster counters.
// STRUCTURE
//  - Shared package hub75_pkg: FSM state encodings (FILL, WAIT) and a line-index split
//    helper constant set (bank/row widths) reused by write-in and scan stages.
//  - No sub-module: FSM, column counter and line counter inline.
// TESTING  (N_BANKS=2, N_ROWS=32, N_COLS=64, wr_row_rdy model: drops 1 cyc after store,
//  returns after 130 cyc)
//  - 64 pixels back-to-back, rdy=1 -> wr_en 64 cycles, cols 0..63; store+swap on cycle 65
//    with bank=0,row=0; in_ready low exactly 1 cycle.
//  - Second row immediately, rdy low -> in_ready=0 after col 63 until rdy rises; one
//    store+swap, bank=0,row=1; no pixel lost or duplicated.
//  - Stream 64 rows -> row 32 commits as bank=1,row=0; row 63 commit pulses frame_done;
//    next row commits bank=0,row=0.
//  - in_valid gaps (1-of-3 duty) -> col advances only on accepts; same commit addresses.
//  - SOF_RESYNC_EN: in_sof at col 10 of y=5 -> sync_err=1, no store, next store bank=0,
//    row=0 after 63 more pixels; without macro: no effect, store at y=5 as normal.
//  - rst asserted at col 40 in WAIT-free FILL -> no store/swap, restart at col=0, y=0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared HUB75 frame-buffer definitions: row-loader FSM states and the default
// panel geometry used to split a display line index into bank and row.
package hub75_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_WAIT = 1'b1
  } row_state_t;

  localparam int DEF_N_BANKS  = 2;
  localparam int DEF_N_ROWS   = 32;
  localparam int DEF_N_COLS   = 64;
  localparam int DEF_BITDEPTH = 24;

  // Line index = {bank, row}; bank occupies the upper bits.
  localparam int DEF_LOG_N_BANKS = $clog2(DEF_N_BANKS);
  localparam int DEF_LOG_N_ROWS  = $clog2(DEF_N_ROWS);
  localparam int DEF_LOG_N_COLS  = $clog2(DEF_N_COLS);
  localparam int DEF_LINE_BITS   = DEF_LOG_N_BANKS + DEF_LOG_N_ROWS;

endpackage

// File: rtl/hub75_fb_row_loader.sv
// Raster pixel stream -> write-in line buffer feeder with row swap/store handover.
// Optional SOF resync enabled by defining HUB75_ROW_LOADER_SOF_RESYNC_EN.
module hub75_fb_row_loader
  import hub75_pkg::*;
#(
  parameter int N_BANKS     = DEF_N_BANKS,
  parameter int N_ROWS      = DEF_N_ROWS,
  parameter int N_COLS      = DEF_N_COLS,
  parameter int BITDEPTH    = DEF_BITDEPTH,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]  wr_row_addr,
  output logic                   wr_row_store,
  input  logic                   wr_row_rdy,
  output logic                   wr_row_swap,
  output logic [BITDEPTH-1:0]    wr_data,
  output logic [LOG_N_COLS-1:0]  wr_col_addr,
  output logic                   wr_en,
  output logic                   frame_done,
  output logic                   sync_err
);

  localparam int LINE_BITS = LOG_N_BANKS + LOG_N_ROWS;

  row_state_t            state;
  logic [LOG_N_COLS-1:0] col;
  logic [LINE_BITS-1:0]  line;

  logic accept;
  logic last_col;
  logic commit;
  logic resync;

  assign in_ready = (state == ST_FILL);
  assign accept   = in_valid & in_ready;
  assign last_col = (col == LOG_N_COLS'(N_COLS - 1));
  // Handover only happens when write-in is idle, so the half we refill next is free.
  assign commit   = (state == ST_WAIT) & wr_row_rdy;

`ifdef HUB75_ROW_LOADER_SOF_RESYNC_EN
  assign resync = accept & in_sof & ((col != '0) | (line != '0));
`else
  logic unused_sof;
  assign unused_sof = in_sof;
  assign resync     = 1'b0;
`endif

  assign wr_data      = in_data;
  assign wr_en        = accept;
  assign wr_col_addr  = resync ? '0 : col;
  assign wr_bank_addr = line[LINE_BITS-1 -: LOG_N_BANKS];
  assign wr_row_addr  = line[LOG_N_ROWS-1:0];
  assign wr_row_store = commit;
  assign wr_row_swap  = commit;
  assign frame_done   = commit & (line == LINE_BITS'(N_BANKS * N_ROWS - 1));
  assign sync_err     = resync;

  // Row FSM with column and line counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
      col   <= '0;
      line  <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (resync) begin
            // Resync pixel lands at column 0 of line 0; partial row is dropped.
            col  <= LOG_N_COLS'(1);
            line <= '0;
          end else if (accept) begin
            col <= col + LOG_N_COLS'(1);
            if (last_col) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wr_row_rdy) begin
            line  <= line + LINE_BITS'(1);
            state <= ST_FILL;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_fb_row_loader.sv
// Self-checking bench for hub75_fb_row_loader: raster-level model compared every cycle
// plus literal checks on commit timing/addresses (HUB75_ROW_LOADER_SOF_RESYNC_EN aware).
module tb_hub75_fb_row_loader;

  localparam int N_BANKS  = 2;
  localparam int N_ROWS   = 32;
  localparam int N_COLS   = 64;
  localparam int BITDEPTH = 24;
  localparam int N_LINES  = N_BANKS * N_ROWS;
`ifdef HUB75_ROW_LOADER_SOF_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [BITDEPTH-1:0] in_data = '0;
  logic                in_sof = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [0:0]          wr_bank_addr;
  logic [4:0]          wr_row_addr;
  logic                wr_row_store;
  logic                wr_row_rdy = 1'b1;
  logic                wr_row_swap;
  logic [BITDEPTH-1:0] wr_data;
  logic [5:0]          wr_col_addr;
  logic                wr_en;
  logic                frame_done;
  logic                sync_err;

  hub75_fb_row_loader #(
    .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .BITDEPTH(BITDEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .wr_bank_addr(wr_bank_addr), .wr_row_addr(wr_row_addr),
    .wr_row_store(wr_row_store), .wr_row_rdy(wr_row_rdy), .wr_row_swap(wr_row_swap),
    .wr_data(wr_data), .wr_col_addr(wr_col_addr), .wr_en(wr_en),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write-in readiness model: busy for 130 cycles starting the cycle after a store.
  bit saw_store = 1'b0;
  int busy = 0;
  always @(posedge clk) begin
    #1;
    if (saw_store) begin
      busy = 130;
      saw_store = 1'b0;
    end
    if (busy > 0) begin
      busy--;
      wr_row_rdy = 1'b0;
    end else begin
      wr_row_rdy = 1'b1;
    end
  end

  // Raster model: pixels placed in the current row, line index, row-complete flag.
  int m_col = 0, m_line = 0;
  bit m_full = 1'b0;
  int c_bank[$], c_row[$], c_fd[$], c_cyc[$];
  int acc_total = 0, first_acc_cyc = -1, acc65_cyc = -1, n_sync = 0;

  always @(negedge clk) begin
    bit acc, rs, st;
    if (rst) begin
      m_col = 0; m_line = 0; m_full = 1'b0;
    end
    acc = in_valid && !m_full;
    rs  = RESYNC && acc && in_sof && (m_col != 0 || m_line != 0);
    st  = m_full && wr_row_rdy;
    chk("in_ready", in_ready, !m_full);
    chk("wr_en", wr_en, acc);
    chk("wr_row_store", wr_row_store, st);
    chk("wr_row_swap", wr_row_swap, st);
    chk("frame_done", frame_done, st && m_line == N_LINES - 1);
    chk("sync_err", sync_err, rs);
    if (acc) begin
      chk("wr_col_addr", wr_col_addr, rs ? 0 : m_col);
      chk("wr_data", wr_data, in_data);
    end
    if (st) begin
      chk("wr_bank_addr", wr_bank_addr, m_line / N_ROWS);
      chk("wr_row_addr", wr_row_addr, m_line % N_ROWS);
    end
    if (wr_row_store) begin
      c_bank.push_back(int'(wr_bank_addr));
      c_row.push_back(int'(wr_row_addr));
      c_fd.push_back(int'(frame_done));
      c_cyc.push_back(cyc);
      saw_store = 1'b1;
    end
    if (sync_err) n_sync++;
    if (wr_en) begin
      acc_total++;
      if (acc_total == 1) first_acc_cyc = cyc;
      if (acc_total == 65) acc65_cyc = cyc;
    end
    if (!rst) begin
      if (m_full) begin
        if (wr_row_rdy) begin
          m_full = 1'b0;
          m_line = (m_line + 1) % N_LINES;
        end
      end else if (rs) begin
        m_col = 1; m_line = 0;
      end else if (acc) begin
        if (m_col == N_COLS - 1) begin
          m_col = 0; m_full = 1'b1;
        end else begin
          m_col++;
        end
      end
    end
  end

  task automatic send_pix(input int n, input int gap, input int sof_idx);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int waitc;
      in_valid = 1'b1;
      in_data  = BITDEPTH'($urandom);
      in_sof   = (i == sof_idx);
      acc = 1'b0;
      waitc = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        waitc++;
        if (!acc && waitc > 400) begin
          n_cmp++; n_bad++;
          $display("FAIL accept_timeout: pixel %0d not accepted after %0d cycles", i, waitc);
          acc = 1'b1;
        end
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_commits(input int target);
    int w = 0;
    while (c_bank.size() < target && w < 400) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("commit_timeout", c_bank.size() >= target, 1);
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  initial begin
    int n_before;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // Row 0 back-to-back with rdy high, then row 1 immediately while write-in is busy.
    send_pix(2 * N_COLS, 0, -1);
    // Row 2 with 1-of-3 valid duty.
    send_pix(N_COLS, 2, -1);
    // Rows 3..63 and the first row of the next frame, then lines 1..4.
    send_pix(66 * N_COLS, 0, -1);
    // Line 5: SOF on column 10, then 63 more pixels.
    send_pix(N_COLS + 10, 0, 10);
    wait_commits(70);
    chk("lit_sof_commit_row", q_at(c_row, 69), RESYNC ? 0 : 5);
    chk("lit_sof_commit_bank", q_at(c_bank, 69), 0);
    chk("lit_sync_err_pulses", n_sync, RESYNC ? 1 : 0);
    // Partial row then reset mid-FILL.
    send_pix(30, 0, -1);
    n_before = c_bank.size();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("lit_no_commit_on_reset", c_bank.size(), n_before);
    send_pix(N_COLS, 0, -1);
    wait_commits(n_before + 1);
    chk("lit_post_reset_bank", q_at(c_bank, n_before), 0);
    chk("lit_post_reset_row", q_at(c_row, n_before), 0);

    chk("lit_row0_latency", q_at(c_cyc, 0) - first_acc_cyc, 64);
    chk("lit_commit_to_accept", acc65_cyc - q_at(c_cyc, 0), 1);
    chk("lit_rdy_wait", q_at(c_cyc, 1) - q_at(c_cyc, 0), 131);
    chk("lit_c0_bank", q_at(c_bank, 0), 0);
    chk("lit_c0_row", q_at(c_row, 0), 0);
    chk("lit_c1_row", q_at(c_row, 1), 1);
    chk("lit_c2_row", q_at(c_row, 2), 2);
    chk("lit_c32_bank", q_at(c_bank, 32), 1);
    chk("lit_c32_row", q_at(c_row, 32), 0);
    chk("lit_c62_fd", q_at(c_fd, 62), 0);
    chk("lit_c63_fd", q_at(c_fd, 63), 1);
    chk("lit_c63_row", q_at(c_row, 63), 31);
    chk("lit_c64_bank", q_at(c_bank, 64), 0);
    chk("lit_c64_row", q_at(c_row, 64), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
